// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the memory access unit: XLEN selectors, funct3 width codes and FSM states.
package mem_access_unit_pkg;

    localparam int XLEN_32B = 1;
    localparam int XLEN_64B = 2;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_D  = 3'b011,
        LS_BU = 3'b100,
        LS_HU = 3'b101,
        LS_WU = 3'b110
    } ls_width_t;

    typedef enum logic {
        LSU_IDLE  = 1'b0,
        LSU_SD_HI = 1'b1
    } lsu_state_t;

    // size is log2 of the access width in bytes (funct3[1:0])
    function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            2'b10:   return |addr_lo[1:0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data memory bus between the access unit (master) and the byte-addressed memory (slave).
interface mem_access_unit_if #(
    parameter int W = 64
);
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_data;
    logic [W-1:0] mem_rdata;
    logic         mem_write;
    logic         store_byte;
    logic         store_half;

    modport master (
        output mem_addr, mem_data, mem_write, store_byte, store_half,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_data, mem_write, store_byte, store_half,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational sign/zero extension of raw memory read data according to the load width.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] rdata,
    input  logic [2:0]   funct3,
    output logic [W-1:0] data
);

    always_comb begin
        data = rdata;
        case (funct3)
            LS_B:    data = W'($signed(rdata[7:0]));
            LS_H:    data = W'($signed(rdata[15:0]));
            LS_W:    data = W'($signed(rdata[31:0]));
            LS_BU:   data = W'(rdata[7:0]);
            LS_HU:   data = W'(rdata[15:0]);
            LS_WU:   data = W'(rdata[31:0]);
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the byte-addressed data memory: width decode, strobes, fault
// detection, registered load extension, and splitting of 64-bit stores into two word writes.
//
// state     | meaning
// LSU_IDLE  | accept requests; loads, B/H/W stores and the SD low word issue here
// LSU_SD_HI | write the latched SD high word; request inputs ignored
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = XLEN_64B,
    localparam int W = 1 << (XLEN + 4)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_enable,
    input  logic              i_valid,
    input  logic              i_load,
    input  logic              i_store,
    input  logic [2:0]        i_funct3,
    input  logic [W-1:0]      i_addr,
    input  logic [W-1:0]      i_wdata,
    output logic              o_stall,
    mem_access_unit_if.master bus,
    output logic              o_load_valid,
    output logic [W-1:0]      o_load_data,
    output logic              o_fault,
    output logic [W-1:0]      o_fault_addr
);

    localparam bit IS_32 = (XLEN == XLEN_32B);

    lsu_state_t   state_q, state_d;
    logic [W-1:0] sd_addr_q;
    logic [31:0]  sd_data_q;

    logic [1:0]   size;
    logic         illegal;
    logic         in_idle;
    logic         fault_now;
    logic         load_ok;
    logic         store_ok;
    logic         sd_now;
    logic [31:0]  wdata_hi;
    logic [W-1:0] ext_data;

    assign size     = i_funct3[1:0];
    assign in_idle  = (state_q == LSU_IDLE);
    assign illegal  = (i_load & i_store)
                    | (i_funct3 == 3'b111)
                    | (i_store & i_funct3[2])
                    | misaligned(i_addr[2:0], size)
                    | (IS_32 & ((i_funct3 == LS_D) | (i_funct3 == LS_WU)));
    assign fault_now = in_idle & i_valid & (i_load | i_store) & illegal;
    assign load_ok   = in_idle & i_valid & i_load & ~illegal;
    assign store_ok  = in_idle & i_valid & i_store & ~illegal;
    assign sd_now    = store_ok & (size == 2'b11);
    // Shift rather than slice so the expression stays legal when W is 32
    assign wdata_hi  = 32'(i_wdata >> 32);

    mem_access_unit_load_extend #(.W(W)) u_load_extend (
        .rdata  (bus.mem_rdata),
        .funct3 (i_funct3),
        .data   (ext_data)
    );

    always_comb begin
        state_d        = state_q;
        bus.mem_addr   = i_addr;
        bus.mem_data   = i_wdata;
        bus.mem_write  = 1'b0;
        bus.store_byte = 1'b0;
        bus.store_half = 1'b0;
        o_stall        = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (store_ok) begin
                    bus.mem_write  = 1'b1;
                    bus.store_byte = (size == 2'b00);
                    bus.store_half = (size == 2'b01);
                end
                if (sd_now) begin
                    bus.mem_data = W'(i_wdata[31:0]);
                    o_stall      = 1'b1;
                    state_d      = LSU_SD_HI;
                end
            end
            LSU_SD_HI: begin
                bus.mem_addr  = sd_addr_q;
                bus.mem_data  = W'(sd_data_q);
                bus.mem_write = 1'b1;
                state_d       = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
        if (!i_clk_enable) begin
            bus.mem_write = 1'b0;
        end
        // Reset must silence the memory and upstream immediately, not at the next edge
        if (i_rst) begin
            bus.mem_write = 1'b0;
            o_stall       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= LSU_IDLE;
            sd_addr_q    <= '0;
            sd_data_q    <= '0;
            o_load_valid <= 1'b0;
            o_load_data  <= '0;
            o_fault      <= 1'b0;
            o_fault_addr <= '0;
        end else if (i_clk_enable) begin
            state_q      <= state_d;
            o_load_valid <= load_ok;
            o_fault      <= fault_now;
            if (load_ok) begin
                o_load_data <= ext_data;
            end
            if (fault_now) begin
                o_fault_addr <= i_addr;
            end
            if (sd_now) begin
                sd_addr_q <= i_addr + W'(4);
                sd_data_q <= wdata_hi;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-array reference memory.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        valid = 1'b0;
    logic        ld = 1'b0;
    logic        st = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        stall;
    logic        load_valid;
    logic [63:0] load_data;
    logic        fault;
    logic [63:0] fault_addr;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] phys_mem [0:4095];
    logic [7:0] ref_mem  [0:4095];

    mem_access_unit_if #(.W(64)) bus();

    mem_access_unit #(.XLEN(XLEN_64B)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clk_enable (clk_en),
        .i_valid      (valid),
        .i_load       (ld),
        .i_store      (st),
        .i_funct3     (f3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_stall      (stall),
        .bus          (bus),
        .o_load_valid (load_valid),
        .o_load_data  (load_data),
        .o_fault      (fault),
        .o_fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [63:0] a);
        return int'(a[11:0]);
    endfunction

    function automatic int wr_bytes(input logic sb, input logic sh);
        return sb ? 1 : (sh ? 2 : 4);
    endfunction

    // Memory seen by the DUT: combinational read, up to 4 bytes committed per write
    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 8; i++)
            bus.mem_rdata[8*i +: 8] = phys_mem[idx(bus.mem_addr + 64'(i))];
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            for (int i = 0; i < 4; i++)
                if (i < wr_bytes(bus.store_byte, bus.store_half))
                    phys_mem[idx(bus.mem_addr + 64'(i))] <= bus.mem_data[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [2:0] f, input logic [63:0] a);
        int          n;
        logic [63:0] v;
        n = 1 << f[1:0];
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (64'(ref_mem[idx(a + 64'(i))]) << (8 * i));
        if (f < 3'd4 && n < 8 && v[8*n-1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [63:0] d, input int n);
        for (int i = 0; i < n; i++)
            ref_mem[idx(a + 64'(i))] = d[8*i +: 8];
    endtask

    task automatic do_req(input logic v, input logic l, input logic s, input logic [2:0] f,
                          input logic [63:0] a, input logic [63:0] d);
        int          n;
        logic        illegal, exp_fault, ld_ok, st_ok, is_sd;
        logic [63:0] exp_ld;
        @(negedge clk);
        valid = v; ld = l; st = s; f3 = f; addr = a; wdata = d;
        n         = 1 << f[1:0];
        illegal   = (l && s) || (f == 3'd7) || (s && f >= 3'd4) || ((a % 64'(n)) != 0);
        exp_fault = v && (l || s) && illegal;
        ld_ok     = v && l && !illegal;
        st_ok     = v && s && !illegal;
        is_sd     = st_ok && (n == 8);
        exp_ld    = ref_load(f, a);
        #1;
        chk("wr_en", 64'(bus.mem_write), 64'(st_ok));
        chk("stall", 64'(stall), 64'(is_sd));
        if (st_ok) begin
            chk("wr_addr", bus.mem_addr, a);
            chk("wr_byte", 64'(bus.store_byte), 64'(n == 1));
            chk("wr_half", 64'(bus.store_half), 64'(n == 2));
            if (is_sd) chk("sd_lo_data", 64'(bus.mem_data[31:0]), 64'(d[31:0]));
            else       chk("wr_data", bus.mem_data, d);
        end
        if (ld_ok) chk("ld_addr", bus.mem_addr, a);
        @(posedge clk);
        #1;
        chk("ld_valid", 64'(load_valid), 64'(ld_ok));
        if (ld_ok) chk("ld_data", load_data, exp_ld);
        chk("fault", 64'(fault), 64'(exp_fault));
        if (exp_fault) chk("fault_addr", fault_addr, a);
        if (st_ok) ref_store(a, d, n);
        if (is_sd) begin
            chk("sd_hi_wr", 64'(bus.mem_write), 64'd1);
            chk("sd_hi_addr", bus.mem_addr, a + 64'd4);
            chk("sd_hi_data", 64'(bus.mem_data[31:0]), 64'(d[63:32]));
            chk("sd_hi_stall", 64'(stall), 64'd0);
            chk("sd_hi_strb", {62'd0, bus.store_byte, bus.store_half}, 64'd0);
            @(posedge clk);
            #1;
            chk("sd_hi_ld_valid", 64'(load_valid), 64'd0);
            chk("sd_hi_fault", 64'(fault), 64'd0);
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [63:0] a, d;
        logic [2:0]  f;
        logic        v, l, s;
        int          sel;

        for (int i = 0; i < 4096; i++) begin
            b = 8'($urandom);
            phys_mem[i] <= b;
            ref_mem[i] = b;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ld_valid", 64'(load_valid), 64'd0);
        chk("rst_ld_data", load_data, 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_fault_addr", fault_addr, 64'd0);
        chk("rst_wr", 64'(bus.mem_write), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Byte load sign/zero extension of 0x80
        do_req(1, 0, 1, 3'd0, 64'h100, 64'h80);
        do_req(1, 1, 0, 3'd0, 64'h100, 64'h0);
        chk("lb_const", load_data, 64'hFFFF_FFFF_FFFF_FF80);
        do_req(1, 1, 0, 3'd4, 64'h100, 64'h0);
        chk("lbu_const", load_data, 64'h80);

        do_req(1, 0, 1, 3'd1, 64'h202, 64'hBEEF);
        do_req(1, 1, 0, 3'd5, 64'h202, 64'h0);
        chk("lhu_const", load_data, 64'hBEEF);

        do_req(1, 0, 1, 3'd3, 64'h300, 64'h1122_3344_5566_7788);
        do_req(1, 1, 0, 3'd3, 64'h300, 64'h0);
        chk("ld_const", load_data, 64'h1122_3344_5566_7788);

        do_req(1, 1, 0, 3'd2, 64'h101, 64'h0);
        chk("lw_mis_fault_addr", fault_addr, 64'h101);
        do_req(0, 0, 0, 3'd0, 64'h0, 64'h0);

        // Reset while the SD high word is pending
        @(negedge clk);
        valid = 1; ld = 0; st = 1; f3 = 3'd3; addr = 64'h400; wdata = 64'hCAFE_F00D_1234_5678;
        #1;
        chk("rsd_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        chk("rsd_hi_wr", 64'(bus.mem_write), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rsd_async_stall", 64'(stall), 64'd0);
        chk("rsd_async_wr", 64'(bus.mem_write), 64'd0);
        chk("rsd_fault_addr", fault_addr, 64'd0);
        ref_store(64'h400, 64'hCAFE_F00D_1234_5678, 4);
        @(negedge clk);
        valid = 0; st = 0;
        @(negedge clk);
        rst = 1'b0;
        do_req(1, 1, 0, 3'd6, 64'h404, 64'h0);
        do_req(1, 1, 0, 3'd3, 64'h400, 64'h0);

        // Clock enable held low during SD high-word cycle
        @(negedge clk);
        valid = 1; ld = 0; st = 1; f3 = 3'd3; addr = 64'h500; wdata = 64'hA1B2_C3D4_E5F6_0718;
        @(posedge clk);
        #1;
        @(negedge clk);
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("en_lo_wr", 64'(bus.mem_write), 64'd0);
            @(posedge clk);
            #1;
            chk("en_lo_hold_wr", 64'(bus.mem_write), 64'd0);
            @(negedge clk);
        end
        clk_en = 1'b1;
        #1;
        chk("en_hi_wr", 64'(bus.mem_write), 64'd1);
        chk("en_hi_addr", bus.mem_addr, 64'h504);
        chk("en_hi_data", 64'(bus.mem_data[31:0]), 64'hA1B2_C3D4);
        ref_store(64'h500, 64'hA1B2_C3D4_E5F6_0718, 8);
        @(posedge clk);
        do_req(1, 1, 0, 3'd3, 64'h500, 64'h0);
        chk("en_ld_const", load_data, 64'hA1B2_C3D4_E5F6_0718);

        for (int k = 0; k < 400; k++) begin
            f   = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            l   = (sel < 5);
            s   = (sel >= 4 && sel < 9);
            v   = ($urandom_range(0, 9) != 0);
            a   = 64'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f[1:0]) - 64'd1);
            if ($urandom_range(0, 15) == 0) a = a | 64'hFFFF_FFFF_FFFF_F000;
            d   = {$urandom, $urandom};
            do_req(v, l, s, f, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
